// File: rtl/instr_mem_pipe.sv
// Pipelined instruction memory: valid/ready fetch port, READ_LATENCY-deep read pipeline,
// response FIFO sized so an accepted fetch always has a slot, plus flush and program-load write port.
module instr_mem_pipe #(
    parameter int ADDR_BITS    = 10,
    parameter int DATA_BITS    = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_BITS-1:0] resp_data,
    output logic [ADDR_BITS-1:0] resp_addr,
    input  logic                 flush,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data
);
    localparam int CAP   = READ_LATENCY + 2;
    localparam int CW    = $clog2(CAP + 1);
    localparam int PW    = $clog2(CAP);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic                 pipe_vld_q  [READ_LATENCY];
    logic                 pipe_vld_d  [READ_LATENCY];
    logic [ADDR_BITS-1:0] pipe_addr_q [READ_LATENCY];
    logic [ADDR_BITS-1:0] pipe_addr_d [READ_LATENCY];
    logic [DATA_BITS-1:0] pipe_data_q [READ_LATENCY];
    logic [DATA_BITS-1:0] pipe_data_d [READ_LATENCY];

    logic [ADDR_BITS-1:0] fifo_addr_q [CAP];
    logic [ADDR_BITS-1:0] fifo_addr_d [CAP];
    logic [DATA_BITS-1:0] fifo_data_q [CAP];
    logic [DATA_BITS-1:0] fifo_data_d [CAP];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]        count_q, count_d;

    logic                 req_fire, resp_fire, fifo_empty, last_vld, push, pop;
    logic [DATA_BITS-1:0] rd_word;

    assign rd_word    = mem[req_addr];
    assign req_ready  = !rst && !flush && (count_q < CW'(CAP));
    assign req_fire   = req_valid && req_ready;
    assign fifo_empty = (fifo_cnt_q == '0);
    assign last_vld   = pipe_vld_q[READ_LATENCY-1];

    // With the FIFO empty the last pipeline stage is presented directly, so the
    // FIFO adds no latency; it only catches entries the consumer cannot take yet.
    assign resp_valid = !fifo_empty || last_vld;
    assign resp_data  = fifo_empty ? pipe_data_q[READ_LATENCY-1] : fifo_data_q[rd_ptr_q];
    assign resp_addr  = fifo_empty ? pipe_addr_q[READ_LATENCY-1] : fifo_addr_q[rd_ptr_q];
    assign resp_fire  = resp_valid && resp_ready;
    assign pop        = resp_fire && !fifo_empty;
    assign push       = last_vld && !(resp_fire && fifo_empty);

    always_comb begin
        pipe_vld_d  = pipe_vld_q;
        pipe_addr_d = pipe_addr_q;
        pipe_data_d = pipe_data_q;
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        count_d     = count_q + CW'(req_fire) - CW'(resp_fire);

        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end
        pipe_vld_d[0] = req_fire;
        if (req_fire) begin
            pipe_addr_d[0] = req_addr;
            pipe_data_d[0] = rd_word;
        end

        if (push) begin
            fifo_addr_d[wr_ptr_q] = pipe_addr_q[READ_LATENCY-1];
            fifo_data_d[wr_ptr_q] = pipe_data_q[READ_LATENCY-1];
            wr_ptr_d = (wr_ptr_q == PW'(CAP - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(CAP - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);

        if (flush) begin
            pipe_vld_d = '{default: '0};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q  <= '{default: '0};
            pipe_addr_q <= '{default: '0};
            pipe_data_q <= '{default: '0};
            fifo_addr_q <= '{default: '0};
            fifo_data_q <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            count_q     <= '0;
        end else begin
            pipe_vld_q  <= pipe_vld_d;
            pipe_addr_q <= pipe_addr_d;
            pipe_data_q <= pipe_data_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            count_q     <= count_d;
        end
    end

    // Program load stays live through reset; memory contents are never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end
endmodule

// File: tb/tb_instr_mem_pipe.sv
// Bench for instr_mem_pipe: three instances (READ_LATENCY 1, 2, 3) share one stimulus stream
// and are each checked against a queue model of outstanding fetches with their due cycle.
module tb_instr_mem_pipe;
    logic        clk = 1'b0;
    logic        rst, req_valid, resp_ready, flush, wr_en;
    logic [9:0]  req_addr, wr_addr;
    logic [31:0] wr_data;

    logic [2:0]       rdy, vld;
    logic [2:0][31:0] dat;
    logic [2:0][9:0]  adr;

    always #5 clk = ~clk;

    instr_mem_pipe #(.ADDR_BITS(10), .DATA_BITS(32), .READ_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_addr(req_addr),
        .resp_valid(vld[0]), .resp_ready(resp_ready), .resp_data(dat[0]), .resp_addr(adr[0]),
        .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));
    instr_mem_pipe #(.ADDR_BITS(10), .DATA_BITS(32), .READ_LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_addr(req_addr),
        .resp_valid(vld[1]), .resp_ready(resp_ready), .resp_data(dat[1]), .resp_addr(adr[1]),
        .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));
    instr_mem_pipe #(.ADDR_BITS(10), .DATA_BITS(32), .READ_LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]), .req_addr(req_addr),
        .resp_valid(vld[2]), .resp_ready(resp_ready), .resp_data(dat[2]), .resp_addr(adr[2]),
        .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

    // Reference: memory image plus, per instance, ordered outstanding fetches
    // (address, data captured at acceptance, first cycle the response may appear).
    logic [31:0] mem_m [16];
    int          qn [3];
    logic [9:0]  qa [3][8];
    logic [31:0] qd [3][8];
    int          qt [3][8];
    int          n;
    int          checks;
    int          errors;
    bit          chk_en;
    logic [31:0] prog [3];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s L%0d observed=%h expected=%h", tag, k + 1, obs, exp);
        end
    endtask

    task automatic step();
        bit efr [3];
        bit eff [3];
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            bit er, ev;
            er = !rst && !flush && (qn[k] < k + 3);
            ev = (qn[k] > 0) && (qt[k][0] <= n);
            if (chk_en) begin
                chk("req_ready", k, 32'(rdy[k]), 32'(er));
                chk("resp_valid", k, 32'(vld[k]), 32'(ev));
                if (ev) begin
                    chk("resp_data", k, dat[k], qd[k][0]);
                    chk("resp_addr", k, 32'(adr[k]), 32'(qa[k][0]));
                end
            end
            efr[k] = er && req_valid;
            eff[k] = ev && resp_ready;
        end
        @(posedge clk);
        n++;
        for (int k = 0; k < 3; k++) begin
            if (rst || flush) begin
                qn[k] = 0;
            end else begin
                if (eff[k]) begin
                    for (int j = 0; j < 7; j++) begin
                        qa[k][j] = qa[k][j+1];
                        qd[k][j] = qd[k][j+1];
                        qt[k][j] = qt[k][j+1];
                    end
                    qn[k]--;
                end
                if (efr[k]) begin
                    qa[k][qn[k]] = req_addr;
                    qd[k][qn[k]] = mem_m[req_addr[3:0]];
                    qt[k][qn[k]] = n + k;
                    qn[k]++;
                end
            end
        end
        if (wr_en) mem_m[wr_addr[3:0]] = wr_data;
        chk_en = 1'b1;
        #1;
    endtask

    task automatic req(input bit v, input int a, input bit rr);
        req_valid  = v;
        req_addr   = 10'(a);
        resp_ready = rr;
        step();
    endtask

    initial begin
        checks = 0; errors = 0; n = 0; chk_en = 1'b0;
        for (int k = 0; k < 3; k++) qn[k] = 0;
        prog[0] = 32'h00500093; prog[1] = 32'h00a00113; prog[2] = 32'h002081b3;
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; flush = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; req_addr = '0;

        // program load while held in reset
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = 10'(i);
            wr_data = (i < 3) ? prog[i] : $urandom;
            step();
        end
        wr_en = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_resp_data", k, dat[k], 32'h0);
            chk("rst_resp_addr", k, 32'(adr[k]), 32'h0);
        end

        // back-to-back fetch of the loaded program
        req(1, 0, 1); req(1, 1, 1); req(1, 2, 1);
        for (int i = 0; i < 4; i++) req(0, 0, 1);

        // streaming, consumer always ready
        for (int i = 0; i < 16; i++) req(1, i, 1);
        for (int i = 0; i < 5; i++) req(0, 0, 1);

        // back-pressure fills to capacity, then drain
        for (int i = 0; i < 8; i++) req(1, i, 0);
        for (int i = 0; i < 8; i++) req(1, 8 + i, 1);
        for (int i = 0; i < 6; i++) req(0, 0, 1);

        // flush with fetches in flight, then a fresh fetch
        req(1, 3, 1); req(1, 4, 1); req(1, 5, 1);
        flush = 1'b1; req(1, 6, 1); flush = 1'b0;
        req(1, 7, 1);
        for (int i = 0; i < 5; i++) req(0, 0, 1);

        // same-cycle write/read is read-first
        wr_en = 1'b1; wr_addr = 10'd5; wr_data = 32'hDEADBEEF;
        req(1, 5, 1);
        wr_en = 1'b0;
        req(1, 5, 1);
        for (int i = 0; i < 5; i++) req(0, 0, 1);

        // reset with the FIFO full; memory survives
        for (int i = 0; i < 8; i++) req(1, i, 0);
        rst = 1'b1; req(0, 0, 0);
        rst = 1'b0; req(0, 0, 0);
        for (int i = 0; i < 6; i++) req(1, i, 1);
        for (int i = 0; i < 5; i++) req(0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 63) == 0);
            flush   = ($urandom_range(0, 15) == 0);
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_addr = 10'($urandom_range(0, 15));
            wr_data = $urandom;
            req($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 2) != 0);
        end
        rst = 1'b0; flush = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 8; i++) req(0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
